sonar_ping_timestamp: RTL
=========================

# sonar_ping_timestamp

Downstream consumer of the SONAR six-bit tick counter. Samples the counter value and four hydrophone detect lines, and timestamps the arrival of one ping on each channel relative to the first channel to fire. It presents per-channel arrival deltas for time-difference-of-arrival bearing logic, handshaked with valid/ack. Counter wrap-around is handled in modulo-64 arithmetic.

## Interface
- WINDOW, default 40: capture window in counter ticks after first arrival; legal range 1..63.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; forces IDLE and clears all outputs.
- arm  in  1  single-cycle request to start a capture; ignored unless in IDLE.
- count  in  6  tick counter value (q of the six-bit counter), sampled every clk.
- detect  in  4  per-channel threshold-crossing level, already synchronous to clk.
- ack  in  1  consumer accepts the result; meaningful only while valid=1.
- busy  out  1  high in ARMED and CAPTURE.
- valid  out  1  high in DONE; results stable while high.
- captured  out  4  bit i set when channel i arrived within the window.
- first_ch  out  4  channels whose edge occurred on the first-arrival cycle.
- delta  out  24  packed {d3,d2,d1,d0}, 6 bits each: ticks from first arrival to channel arrival, mod 64; 0 for uncaptured channels.

## Operation
- Edge detection: detect_d is detect delayed by one clk, updated in every state. The edge vector is detect & ~detect_d. A channel counts at most once per capture.
- FSM states: IDLE, ARMED, CAPTURE, DONE.
  - IDLE: on arm -> ARMED, and clear captured, first_ch and delta. Edges are ignored.
  - ARMED: on the first cycle with any edge, latch t_first = count; set captured = first_ch = the edge vector; their deltas = 0; -> CAPTURE. If that edge vector is 4'b1111 -> DONE directly.
  - CAPTURE: elapsed = (count - t_first) mod 64, 6-bit unsigned wrap. Each edge on a channel with captured=0 sets its captured bit and delta = elapsed. Edges on already-captured channels are ignored. If captured becomes 4'b1111 (including this cycle's updates), or elapsed >= WINDOW -> DONE. When elapsed >= WINDOW, same-cycle edges are not captured.
  - DONE: valid=1 and outputs held. On ack -> IDLE. An arm in the same cycle as ack is ignored.
- The count input may stall (counter enable low); elapsed then stays constant and the window does not advance.
- A wrap of count from 63 to 0 during CAPTURE needs no special handling; the mod-64 subtraction covers it because WINDOW < 64.
- Reset in any state, mid-capture included: next state IDLE. busy, valid, captured, first_ch and delta all become 0, and detect_d becomes 0.

## Timing
- Reset values: busy=0, valid=0, captured=0, first_ch=0, delta=0, state IDLE.
- arm sampled high at edge k: busy=1 after edge k.
- The first edge is visible as detect high and detect_d low during cycle n. t_first = count during cycle n, captured and first_ch update at edge n+1, and busy stays 1.
- valid rises at the edge that evaluates the completion condition, i.e. one edge after the last capture or the window expiry is seen. There is no extra pipeline stage.
- After ack is sampled high at edge m, valid=0 and busy=0 after edge m, and a new arm is accepted from cycle m+1.
- Throughput: at most one capture per arm/ack cycle.

## Test plan
- Sequential arrivals: arm, count=10. Ch2 rises at count 10, ch0 at 13, ch3 at 20, ch1 at 25 -> valid with captured=1111, first_ch=0100, delta d0=3, d1=15, d2=0, d3=10.
- Wrap-around: count=60, ch1 first; ch0 at count 2 -> d0=6; ch2 and ch3 never fire. Window expires at count 36 (elapsed 40) -> captured=0011, d2=d3=0.
- Simultaneous first: ch0 and ch3 rise in the same cycle, then ch1 and ch2 one tick later -> first_ch=1001, d0=d3=0, d1=d2=1, and valid one edge after the ch1/ch2 capture.
- Duplicate and idle edges: edges while IDLE produce no change. Ch0 toggling three times during CAPTURE -> only its first delta is kept. arm while busy is ignored.
- Reset mid-capture: assert reset with captured=0011 -> all outputs 0 next edge, state IDLE. A subsequent arm and capture works normally.
- Handshake: hold ack low 20 cycles in DONE -> outputs stable and further edges ignored. Assert ack and arm together -> returns to IDLE with busy=0, and the arm is not taken.

Source files
------------

// File: rtl/sonar_ping_timestamp.sv
// sonar_ping_timestamp
//
// Timestamps one ping arrival on each of four hydrophone channels. Times are
// taken from the free-running six-bit SONAR tick counter and are relative to
// the first channel that fires. The per-channel deltas are handed to the
// time-difference-of-arrival bearing logic through a valid/ack handshake.
//
// Parameters
//   WINDOW    capture window in counter ticks after the first arrival (1..63)
//
// Ports
//   clk       system clock; all state changes on the rising edge
//   reset     synchronous, active-high; returns to IDLE and clears outputs
//   arm       single-cycle request to start a capture (only taken in IDLE)
//   count     six-bit tick counter value, sampled every clock
//   detect    per-channel threshold-crossing levels, synchronous to clk
//   ack       consumer accepts the result while valid is high
//   busy      high while armed or capturing
//   valid     high while a finished result is presented
//   captured  bit i set when channel i arrived within the window
//   first_ch  channels whose edge fell on the first-arrival cycle
//   delta     {d3,d2,d1,d0}, six bits each: ticks after first arrival, mod 64

module sonar_ping_timestamp #(
  parameter int WINDOW = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        arm,
  input  logic [5:0]  count,
  input  logic [3:0]  detect,
  input  logic        ack,
  output logic        busy,
  output logic        valid,
  output logic [3:0]  captured,
  output logic [3:0]  first_ch,
  output logic [23:0] delta
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  localparam logic [5:0] WIN = 6'(WINDOW);

  state_t      state, state_n;
  logic [3:0]  detect_d;
  logic [5:0]  t_first, t_first_n;
  logic [3:0]  captured_n, first_ch_n;
  logic [23:0] delta_n;

  logic [3:0]  edge_v;
  logic [3:0]  fresh;
  logic [3:0]  merged;
  logic [5:0]  elapsed;
  logic        expired;

  // Registers: state, the one-cycle detect history and the result fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      detect_d <= '0;
      t_first  <= '0;
      captured <= '0;
      first_ch <= '0;
      delta    <= '0;
    end else begin
      state    <= state_n;
      detect_d <= detect;
      t_first  <= t_first_n;
      captured <= captured_n;
      first_ch <= first_ch_n;
      delta    <= delta_n;
    end
  end

  // Next-state and result update. The six-bit subtraction wraps naturally,
  // so a counter rollover during capture needs no special case because the
  // window is always shorter than the counter period. A stalled counter
  // simply freezes elapsed, which also freezes the window.
  always_comb begin
    edge_v     = detect & ~detect_d;
    elapsed    = count - t_first;
    expired    = (elapsed >= WIN);
    fresh      = edge_v & ~captured;
    merged     = captured | fresh;

    state_n    = state;
    t_first_n  = t_first;
    captured_n = captured;
    first_ch_n = first_ch;
    delta_n    = delta;

    case (state)
      IDLE: begin
        if (arm) begin
          state_n    = ARMED;
          captured_n = '0;
          first_ch_n = '0;
          delta_n    = '0;
        end
      end
      ARMED: begin
        if (|edge_v) begin
          t_first_n  = count;
          captured_n = edge_v;
          first_ch_n = edge_v;
          delta_n    = '0;
          state_n    = (edge_v == 4'b1111) ? DONE : CAPTURE;
        end
      end
      CAPTURE: begin
        // Once the window has closed, edges on that same cycle are dropped.
        if (expired) begin
          state_n = DONE;
        end else begin
          captured_n = merged;
          for (int i = 0; i < 4; i++) begin
            if (fresh[i]) delta_n[i*6 +: 6] = elapsed;
          end
          if (merged == 4'b1111) state_n = DONE;
        end
      end
      DONE: begin
        if (ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy  = (state == ARMED) || (state == CAPTURE);
  assign valid = (state == DONE);

endmodule
